half_adder_v4: RTL and testbench



---
 rtl/half_adder_v4.sv | 67 ++++++
 tb/tb_half_adder_v4.sv | 113 +++++++++++
 2 files changed

// File: rtl/half_adder_v4.sv
// Registered half adder with WIDTH independent lanes: sum = a ^ b, carry = a & b.
// A valid operand pair is captured on the rising edge, and the result appears one cycle later.
module half_adder_v4 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             out_valid
);

  logic [WIDTH-1:0] sum_r;
  logic [WIDTH-1:0] carry_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] sum_nxt_s;
  logic [WIDTH-1:0] carry_nxt_s;
  logic             out_valid_nxt_s;

  function automatic logic [WIDTH-1:0] lane_sum(input logic [WIDTH-1:0] op_a,
                                                input logic [WIDTH-1:0] op_b);
    return op_a ^ op_b;
  endfunction

  function automatic logic [WIDTH-1:0] lane_carry(input logic [WIDTH-1:0] op_a,
                                                  input logic [WIDTH-1:0] op_b);
    return op_a & op_b;
  endfunction

  // Next-state selection. Operands are only consumed when in_valid is high,
  // so unknown operands on idle cycles never reach the result registers.
  always_comb begin
    sum_nxt_s       = sum_r;
    carry_nxt_s     = carry_r;
    out_valid_nxt_s = 1'b0;
    if (in_valid) begin
      sum_nxt_s       = lane_sum(a, b);
      carry_nxt_s     = lane_carry(a, b);
      out_valid_nxt_s = 1'b1;
    end else begin
      sum_nxt_s       = sum_r;
      carry_nxt_s     = carry_r;
      out_valid_nxt_s = 1'b0;
    end
  end

  // Result registers with synchronous reset taking priority over capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_r       <= {WIDTH{1'b0}};
      carry_r     <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      sum_r       <= sum_nxt_s;
      carry_r     <= carry_nxt_s;
      out_valid_r <= out_valid_nxt_s;
    end
  end

  assign sum       = sum_r;
  assign carry     = carry_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_half_adder_v4.sv
// Self-checking bench for half_adder_v4: a 1-lane and a 4-lane instance, with directed
// cases from the test plan followed by randomized traffic compared against an arithmetic model.
module tb_half_adder_v4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] a4, b4, sum4, carry4;
  logic [0:0] a1, b1, sum1, carry1;
  logic       ov4, ov1;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: expected registered outputs
  logic [3:0] exp_sum4, exp_carry4;
  logic       exp_sum1, exp_carry1, exp_ov;

  half_adder_v4 #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .sum(sum4), .carry(carry4),
    .a(a4), .b(b4), .in_valid(in_valid), .out_valid(ov4)
  );

  half_adder_v4 #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .sum(sum1), .carry(carry1),
    .a(a1), .b(b1), .in_valid(in_valid), .out_valid(ov1)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model by the capture rule, then compare.
  task automatic step(input logic r, input logic v, input logic [3:0] wa, input logic [3:0] wb,
                      input logic na, input logic nb, input string tag);
    logic [1:0] t;
    rst = r; in_valid = v; a4 = wa; b4 = wb; a1 = na; b1 = nb;
    @(posedge clk);
    if (r) begin
      exp_sum4 = 4'd0; exp_carry4 = 4'd0; exp_sum1 = 1'b0; exp_carry1 = 1'b0; exp_ov = 1'b0;
    end else if (v) begin
      for (int i = 0; i < 4; i++) begin
        t = 2'(wa[i]) + 2'(wb[i]);
        exp_sum4[i]   = t[0];
        exp_carry4[i] = t[1];
      end
      t = 2'(na) + 2'(nb);
      exp_sum1 = t[0]; exp_carry1 = t[1];
      exp_ov = 1'b1;
    end else begin
      exp_ov = 1'b0;
    end
    #1;
    check_val({tag, "_sum4"},   64'(sum4),   64'(exp_sum4));
    check_val({tag, "_carry4"}, 64'(carry4), 64'(exp_carry4));
    check_val({tag, "_ov4"},    64'(ov4),    64'(exp_ov));
    check_val({tag, "_sum1"},   64'(sum1),   64'(exp_sum1));
    check_val({tag, "_carry1"}, 64'(carry1), 64'(exp_carry1));
    check_val({tag, "_ov1"},    64'(ov1),    64'(exp_ov));
  endtask

  initial begin
    logic r, v;
    rst = 1'b1; in_valid = 1'b1; a4 = 4'hF; b4 = 4'hF; a1 = 1'b1; b1 = 1'b1;
    exp_sum4 = 4'd0; exp_carry4 = 4'd0; exp_sum1 = 1'b0; exp_carry1 = 1'b0; exp_ov = 1'b0;

    // Reset held with active operands
    step(1'b1, 1'b1, 4'hF, 4'hF, 1'b1, 1'b1, "rst0");
    step(1'b1, 1'b1, 4'hF, 4'hF, 1'b1, 1'b1, "rst1");
    check_val("rst_const_ov1", 64'(ov1), 64'd0);

    // Exhaustive 1-bit truth table, back to back
    step(1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, "tt00");
    step(1'b0, 1'b1, 4'h5, 4'hA, 1'b0, 1'b1, "tt01");
    check_val("tt01_const", 64'({carry1, sum1}), 64'd1);
    step(1'b0, 1'b1, 4'h3, 4'h0, 1'b1, 1'b0, "tt10");
    step(1'b0, 1'b1, 4'hF, 4'hF, 1'b1, 1'b1, "tt11");
    check_val("tt11_const", 64'({carry1, sum1, ov1}), 64'd5);

    // Hold: results retained while idle, even with new operands on the bus
    step(1'b0, 1'b1, 4'h9, 4'h0, 1'b1, 1'b0, "hold_v");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'hF, 4'hF, 1'b1, 1'b1, "hold_i");
    check_val("hold_const", 64'({sum1, carry1, ov1}), 64'd4);

    // Reset mid-stream discards the pair presented with it
    step(1'b0, 1'b1, 4'hF, 4'hF, 1'b1, 1'b1, "mid0");
    step(1'b1, 1'b1, 4'h0, 4'hF, 1'b0, 1'b1, "mid1");
    step(1'b0, 1'b1, 4'hF, 4'h0, 1'b1, 1'b0, "mid2");
    check_val("mid2_const", 64'({sum1, carry1, ov1}), 64'd5);

    // Lane independence
    step(1'b0, 1'b1, 4'b1100, 4'b1010, 1'b0, 1'b0, "lanes");
    check_val("lanes_sum_const",   64'(sum4),   64'h6);
    check_val("lanes_carry_const", 64'(carry4), 64'h8);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 300; n++) begin
      r = ($urandom_range(0, 15) == 0);
      v = $urandom_range(0, 1) == 1;
      step(r, v, 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
